// File: rtl/time_line_formatter_if.sv
// Mode/button inputs and formatted LCD line outputs of the time line formatter.
interface time_line_formatter_if;
  logic [1:0]   clk_mode;
  logic [1:0]   vButton;
  logic [127:0] LineA;
  logic [127:0] LineB;
  logic         sec_tick;

  modport master (output clk_mode, output vButton, input LineA, input LineB, input sec_tick);
  modport slave  (input clk_mode, input vButton, output LineA, output LineB, output sec_tick);
endinterface

// File: rtl/time_line_formatter.sv
// Weekday/HH:MM:SS timekeeper with button editing; renders two 16-char ASCII lines
// (column k in bits 8k+7:8k) for the LCD controller.
module time_line_formatter #(
  parameter int unsigned MFREQ_KHZ = 1,
  parameter int unsigned TICK_MS   = 1000
) (
  input logic                  mclk,
  input logic                  rst,
  time_line_formatter_if.slave bus
);
  localparam int unsigned P  = MFREQ_KHZ * TICK_MS;
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(P - 1);
  localparam logic [CW-1:0] PRE_HALF = CW'((P / 2 > 0) ? (P / 2 - 1) : 0);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HOUR = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_DAY  = 2'd3
  } mode_t;

  logic [CW-1:0] pre, pre_n;
  logic          blink, blink_n;
  mode_t         mode_q, mode_in;
  logic [5:0]    sec, sec_n, min, min_n;
  logic [4:0]    hr, hr_n;
  logic [2:0]    wday, wday_n, wd;
  logic          tick_n, boundary, mode_chg, inc, dec;

  function automatic logic [15:0] digits(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v % 6'd10;
    return {8'h30 + {2'b00, t}, 8'h30 + {2'b00, o}};
  endfunction

  function automatic logic [23:0] day_name(input logic [2:0] d);
    case (d)
      3'd1:    return "Tue";
      3'd2:    return "Wed";
      3'd3:    return "Thu";
      3'd4:    return "Fri";
      3'd5:    return "Sat";
      3'd6:    return "Sun";
      default: return "Mon";
    endcase
  endfunction

  function automatic logic [127:0] fmt_a(input logic [2:0] d, input logic [4:0] h,
                                         input logic [5:0] m, input logic [5:0] s,
                                         input logic blank, input mode_t md);
    logic [7:0]   c [16];
    logic [23:0]  dn;
    logic [15:0]  hd, mdg, sd;
    logic [127:0] r;
    dn  = day_name(d);
    hd  = digits({1'b0, h});
    mdg = digits(m);
    sd  = digits(s);
    for (int unsigned k = 0; k < 16; k++) c[k] = 8'h20;
    c[0]  = dn[23:16];
    c[1]  = dn[15:8];
    c[2]  = dn[7:0];
    c[4]  = hd[15:8];
    c[5]  = hd[7:0];
    c[6]  = 8'h3A;
    c[7]  = mdg[15:8];
    c[8]  = mdg[7:0];
    c[9]  = 8'h3A;
    c[10] = sd[15:8];
    c[11] = sd[7:0];
    // The field under edit blanks while blink is set; colons stay visible.
    if (blank) begin
      case (md)
        MODE_HOUR: begin c[4] = 8'h20; c[5] = 8'h20; end
        MODE_MIN:  begin c[7] = 8'h20; c[8] = 8'h20; end
        MODE_DAY:  begin c[0] = 8'h20; c[1] = 8'h20; c[2] = 8'h20; end
        default:   ;
      endcase
    end
    r = '0;
    for (int unsigned k = 0; k < 16; k++) r[8*k +: 8] = c[k];
    return r;
  endfunction

  function automatic logic [127:0] fmt_b(input mode_t md);
    logic [63:0]  b;
    logic [127:0] r;
    case (md)
      MODE_HOUR: b = "SET HOUR";
      MODE_MIN:  b = "SET MIN ";
      MODE_DAY:  b = "SET DAY ";
      default:   b = "RUN     ";
    endcase
    r = {16{8'h20}};
    for (int unsigned k = 0; k < 8; k++) r[8*k +: 8] = b[63 - 8*k -: 8];
    return r;
  endfunction

  assign mode_in = mode_t'(bus.clk_mode);

  always_comb begin
    boundary = (pre == PRE_LAST);
    mode_chg = (mode_in != mode_q);
    inc      = (bus.vButton == 2'b01);
    dec      = (bus.vButton == 2'b10);
    wd       = (wday > 3'd6) ? '0 : wday;
    pre_n    = boundary ? '0 : pre + CW'(1);
    blink_n  = blink;
    if (boundary || pre == PRE_HALF) blink_n = ~blink;
    if (mode_chg) blink_n = 1'b0;
    sec_n  = sec;
    min_n  = min;
    hr_n   = hr;
    wday_n = wd;
    tick_n = 1'b0;
    if (mode_in == MODE_RUN) begin
      if (boundary) begin
        tick_n = 1'b1;
        if (sec == 6'd59) begin
          sec_n = '0;
          if (min == 6'd59) begin
            min_n = '0;
            if (hr == 5'd23) begin
              hr_n   = '0;
              wday_n = (wd == 3'd6) ? '0 : wd + 3'd1;
            end else hr_n = hr + 5'd1;
          end else min_n = min + 6'd1;
        end else sec_n = sec + 6'd1;
      end
    end else begin
      if (mode_chg && mode_in == MODE_MIN) sec_n = '0;
      case (mode_in)
        MODE_HOUR:
          if (inc)      hr_n = (hr == 5'd23) ? '0 : hr + 5'd1;
          else if (dec) hr_n = (hr == 5'd0) ? 5'd23 : hr - 5'd1;
        MODE_MIN:
          if (inc)      min_n = (min == 6'd59) ? '0 : min + 6'd1;
          else if (dec) min_n = (min == 6'd0) ? 6'd59 : min - 6'd1;
        MODE_DAY:
          if (inc)      wday_n = (wd == 3'd6) ? '0 : wd + 3'd1;
          else if (dec) wday_n = (wd == 3'd0) ? 3'd6 : wd - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      pre          <= '0;
      blink        <= 1'b0;
      mode_q       <= MODE_RUN;
      sec          <= '0;
      min          <= '0;
      hr           <= '0;
      wday         <= '0;
      bus.sec_tick <= 1'b0;
      bus.LineA    <= fmt_a(3'd0, 5'd0, 6'd0, 6'd0, 1'b0, MODE_RUN);
      bus.LineB    <= fmt_b(MODE_RUN);
    end else begin
      pre          <= pre_n;
      blink        <= blink_n;
      mode_q       <= mode_in;
      sec          <= sec_n;
      min          <= min_n;
      hr           <= hr_n;
      wday         <= wday_n;
      bus.sec_tick <= tick_n;
      bus.LineA    <= fmt_a(wday, hr, min, sec, blink, mode_q);
      bus.LineB    <= fmt_b(mode_q);
    end
  end
endmodule

// File: tb/tb_time_line_formatter.sv
// Directed bench for time_line_formatter with a 4-cycle second (MFREQ_KHZ=1, TICK_MS=4).
module tb_time_line_formatter;
  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  time_line_formatter_if bus ();

  time_line_formatter #(.MFREQ_KHZ(1), .TICK_MS(4)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] MON_C = 24'h6E6F4D;
  localparam logic [23:0] BLK_C = 24'h202020;

  typedef struct packed {
    logic [1:0]   mode;
    logic [1:0]   vb;
    logic [127:0] exp_a;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [127:0] line(input string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int k = 0; k < s.len() && k < 16; k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  function automatic logic [127:0] banner(input logic [1:0] m);
    case (m)
      2'd1:    return line("SET HOUR");
      2'd2:    return line("SET MIN");
      2'd3:    return line("SET DAY");
      default: return line("RUN");
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Overlay four consecutive LineA samples so a blinking field is read when visible.
  task automatic read_merged(output logic [127:0] m);
    m = {16{8'h20}};
    repeat (4) begin
      step();
      for (int k = 0; k < 16; k++)
        if (bus.LineA[8*k +: 8] != 8'h20) m[8*k +: 8] = bus.LineA[8*k +: 8];
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] m;
    logic [127:0] expv;
    logic [23:0]  s [8];
    int           ticks;
    bit           found;

    vecs[0]  = '{2'd1, 2'b10, line("Mon 23:00:01")};
    vecs[1]  = '{2'd1, 2'b01, line("Mon 00:00:01")};
    vecs[2]  = '{2'd1, 2'b11, line("Mon 00:00:01")};
    vecs[3]  = '{2'd1, 2'b10, line("Mon 23:00:01")};
    vecs[4]  = '{2'd2, 2'b10, line("Mon 23:59:00")};
    vecs[5]  = '{2'd2, 2'b01, line("Mon 23:00:00")};
    vecs[6]  = '{2'd2, 2'b10, line("Mon 23:59:00")};
    vecs[7]  = '{2'd3, 2'b10, line("Sun 23:59:00")};
    vecs[8]  = '{2'd3, 2'b01, line("Mon 23:59:00")};
    vecs[9]  = '{2'd3, 2'b10, line("Sun 23:59:00")};
    vecs[10] = '{2'd2, 2'b00, line("Sun 23:59:00")};

    bus.clk_mode = 2'd0;
    bus.vButton  = 2'b00;
    rst = 1'b1;
    step();
    step();
    check("rst_lineA", bus.LineA, line("Mon 00:00:00"));
    check("rst_lineB", bus.LineB, line("RUN"));
    check("rst_tick", bus.sec_tick, 0);
    rst = 1'b0;

    repeat (3) begin
      step();
      check("t1_tick_early", bus.sec_tick, 0);
    end
    step();
    check("t1_tick", bus.sec_tick, 1);
    step();
    check("t1_tick_off", bus.sec_tick, 0);
    check("t1_lineA", bus.LineA, line("Mon 00:00:01"));

    for (int i = 0; i < 11; i++) begin
      bus.clk_mode = vecs[i].mode;
      bus.vButton  = vecs[i].vb;
      step();
      bus.vButton = 2'b00;
      step();
      read_merged(m);
      check($sformatf("vec%0d_lineA", i), m, vecs[i].exp_a);
      check($sformatf("vec%0d_lineB", i), bus.LineB, banner(vecs[i].mode));
    end

    bus.clk_mode = 2'd0;
    ticks = 0;
    for (int c = 0; c < 300 && ticks < 60; c++) begin
      step();
      if (bus.sec_tick) begin
        ticks++;
        if (ticks == 59) begin
          step();
          check("t2_pre_wrap", bus.LineA, line("Sun 23:59:59"));
        end else if (ticks == 60) begin
          step();
          check("t2_wrap", bus.LineA, line("Mon 00:00:00"));
          check("t2_tick_single", bus.sec_tick, 0);
        end
      end
    end
    check("t2_tick_count", ticks, 60);

    ticks = 0;
    found = 1'b0;
    for (int c = 0; c < 1400 && !found; c++) begin
      step();
      if (bus.sec_tick) begin
        ticks++;
        if (ticks == 337) found = 1'b1;
      end
    end
    check("t4_reached", found, 1);
    bus.clk_mode = 2'd2;
    step();
    check("t4_run_value", bus.LineA, line("Mon 00:05:37"));
    step();
    check("t4_sec_cleared", bus.LineA, line("Mon 00:05:00"));
    bus.vButton = 2'b11;
    step();
    bus.vButton = 2'b00;
    step();
    read_merged(m);
    check("t4_both_buttons", m, line("Mon 00:05:00"));

    bus.clk_mode = 2'd3;
    step();
    step();
    check("t5_lineB", bus.LineB, line("SET DAY"));
    for (int i = 0; i < 8; i++) begin
      step();
      s[i] = bus.LineA[23:0];
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_day_chars%0d", i), (s[i] == BLK_C) ? MON_C : s[i], MON_C);
    for (int i = 0; i < 6; i++)
      check($sformatf("t5_blink_alt%0d", i), s[i] ^ s[i+2], MON_C ^ BLK_C);
    expv = line("Mon 00:05:00");
    check("t5_other_cols", bus.LineA[95:32], expv[95:32]);

    bus.clk_mode = 2'd1;
    step();
    step();
    rst = 1'b1;
    bus.vButton = 2'b01;
    step();
    bus.vButton = 2'b00;
    rst = 1'b0;
    bus.clk_mode = 2'd0;
    check("t6_lineA", bus.LineA, line("Mon 00:00:00"));
    check("t6_lineB", bus.LineB, line("RUN"));
    check("t6_tick", bus.sec_tick, 0);
    step();
    step();
    check("t6_after_lineA", bus.LineA, line("Mon 00:00:00"));
    check("t6_after_lineB", bus.LineB, line("RUN"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
